// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one outstanding imem read, one-entry instruction buffer (FETCH_MISALIGN_EN: sticky misaligned-target flag).
// Latency: grant in cycle N, rvalid in N+1, instr_valid in N+2; peak one instruction every two cycles.
// Backpressure: no request while the buffer is full and not being drained; imem_rvalid is never stalled.
module instr_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           instr,
   output logic [6:0]            op,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  misalign_err
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;
   logic                    vld_q, vld_d;
   logic [31:0]             dat_q, dat_d;
   logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
   logic                    slot_free;
   logic [ADDR_WIDTH-1:0]   tgt_pc;

   assign slot_free = !vld_q || instr_ready;
   assign tgt_pc    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      vld_d    = vld_q;
      dat_d    = dat_q;
      ipc_d    = ipc_q;
      imem_req = 1'b0;

      if (vld_q && instr_ready) begin
         vld_d = 1'b0;
      end

      case (state_q)
         ST_RESET: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            imem_req = slot_free;
            if (slot_free && imem_gnt) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + ADDR_WIDTH'(4);
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               dat_d   = imem_rdata;
               ipc_d   = req_pc_q;
               vld_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_RESET;
      endcase

      // A response landing in the redirect cycle retires the read, so DROP is only
      // entered when a response is still owed; otherwise DROP would wait forever.
      if (redirect) begin
         pc_d  = tgt_pc;
         vld_d = 1'b0;
         case (state_q)
            ST_REQ:  state_d = (imem_req && imem_gnt) ? ST_DROP : ST_REQ;
            ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
            ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RESET;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         ipc_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         ipc_q <= ipc_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr_valid = vld_q;
   assign instr       = dat_q;
   assign op          = dat_q[6:0];
   assign instr_pc    = ipc_q;

`ifdef FETCH_MISALIGN_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`else
   logic unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign misalign_err         = 1'b0;
`endif

endmodule
